vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_if.sv | 23 ++
 rtl/wrap_counter.sv | 42 ++++
 rtl/vga_timing.sv | 93 +++++++++
 tb/tb_vga_timing.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, counter type and window helper.
// Defaults describe 1024x768; totals are derived from the four segments.
package vga_pkg;

  localparam int CW = 11;

  typedef logic [CW-1:0] count_t;

  localparam int H_ACTIVE_D = 1024;
  localparam int H_FP_D     = 24;
  localparam int H_SYNC_D   = 136;
  localparam int H_BP_D     = 160;
  localparam int V_ACTIVE_D = 768;
  localparam int V_FP_D     = 3;
  localparam int V_SYNC_D   = 6;
  localparam int V_BP_D     = 29;

  localparam int H_TOTAL_D =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL_D =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  // Half-open window test: lo <= v < hi.
  function automatic logic in_win(
    input count_t v,
    input count_t lo,
    input count_t hi
  );
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: timing bundle from the generator to the pixel pipeline.
// Ports: hcount/vcount (11b), hsync, hblnk, vsync, vblnk.
interface vga_if;
  import vga_pkg::*;

  count_t hcount;
  count_t vcount;
  logic   hsync;
  logic   hblnk;
  logic   vsync;
  logic   vblnk;

  modport out (
    output hcount, vcount,
    output hsync, hblnk, vsync, vblnk
  );

  modport in (
    input hcount, vcount,
    input hsync, hblnk, vsync, vblnk
  );

endinterface

// File: rtl/wrap_counter.sv
// wrap_counter: modulo-MAX counter advancing when en is high.
// Ports: clk, rst (async low), en, count_o, next_o, wrap_out.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int MAX = 16
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output count_t count_o,
  output count_t next_o,
  output logic   wrap_out
);

  localparam count_t LAST = count_t'(MAX - 1);

  count_t count_q;
  count_t count_d;

  assign wrap_out = en && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap_out ? '0 : count_q + count_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Next value lets the parent register flags in step with the count.
  assign next_o  = count_d;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA sync/blank generator with line and frame pulses.
// Ports: clk, rst (async low), en, vout, line_start, frame_start.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  vga_if.out   vout,
  output logic line_start,
  output logic frame_start
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam count_t HB_LO = count_t'(H_ACTIVE);
  localparam count_t HS_LO = count_t'(H_ACTIVE + H_FP);
  localparam count_t HS_HI =
    count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam count_t VB_LO = count_t'(V_ACTIVE);
  localparam count_t VS_LO = count_t'(V_ACTIVE + V_FP);
  localparam count_t VS_HI =
    count_t'(V_ACTIVE + V_FP + V_SYNC);

  count_t h_q, h_d;
  count_t v_q, v_d;
  logic   h_wrap, v_wrap;

  logic hsync_q, hblnk_q;
  logic vsync_q, vblnk_q;
  logic ls_q, fs_q;

  wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count_o  (h_q),
    .next_o   (h_d),
    .wrap_out (h_wrap)
  );

  // Vertical advances only on a horizontal wrap, so v_wrap
  // already implies h_wrap.
  wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .en       (h_wrap),
    .count_o  (v_q),
    .next_o   (v_d),
    .wrap_out (v_wrap)
  );

  // Flags decode the next counts so they land with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= 1'b0;
      hblnk_q <= 1'b0;
      vsync_q <= 1'b0;
      vblnk_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hblnk_q <= h_d >= HB_LO;
      hsync_q <= in_win(h_d, HS_LO, HS_HI);
      vblnk_q <= v_d >= VB_LO;
      vsync_q <= in_win(v_d, VS_LO, VS_HI);
      ls_q    <= h_wrap;
      fs_q    <= v_wrap;
    end
  end

  assign vout.hcount = h_q;
  assign vout.vcount = v_q;
  assign vout.hsync  = hsync_q;
  assign vout.hblnk  = hblnk_q;
  assign vout.vsync  = vsync_q;
  assign vout.vblnk  = vblnk_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: random-enable bench with arithmetic reference model.
// Three instances: default, 640x480, and short-line 640x480 vertical.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  vga_if i0 ();
  vga_if i1 ();
  vga_if i2 ();
  logic ls0, fs0, ls1, fs1, ls2, fs2;

  vga_timing u_d0 (
    .clk (clk), .rst (rst), .en (en), .vout (i0),
    .line_start (ls0), .frame_start (fs0)
  );

  vga_timing #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2), .V_BP (33)
  ) u_d1 (
    .clk (clk), .rst (rst), .en (en), .vout (i1),
    .line_start (ls1), .frame_start (fs1)
  );

  vga_timing #(
    .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2), .V_BP (33)
  ) u_d2 (
    .clk (clk), .rst (rst), .en (en), .vout (i2),
    .line_start (ls2), .frame_start (fs2)
  );

  int HA[3] = '{1024, 640, 8};
  int HF[3] = '{24, 16, 1};
  int HS[3] = '{136, 96, 2};
  int HB[3] = '{160, 48, 1};
  int VA[3] = '{768, 480, 480};
  int VF[3] = '{3, 10, 10};
  int VS[3] = '{6, 2, 2};
  int VB[3] = '{29, 33, 33};

  // Model state: enabled cycles since reset, last edge advanced.
  longint t = 0;
  bit     adv = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] expv(int k);
    longint ht, vt, h, v;
    logic hs, hb, vs, vb, ls, fs;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    h  = t % ht;
    v  = (t / ht) % vt;
    hb = h >= HA[k];
    hs = h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k];
    vb = v >= VA[k];
    vs = v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k];
    ls = adv && h == 0;
    fs = ls && v == 0;
    return {11'(h), 11'(v), hs, hb, vs, vb, ls, fs};
  endfunction

  function automatic logic [27:0] obs(int k);
    case (k)
      0: return {i0.hcount, i0.vcount, i0.hsync, i0.hblnk,
                 i0.vsync, i0.vblnk, ls0, fs0};
      1: return {i1.hcount, i1.vcount, i1.hsync, i1.hblnk,
                 i1.vsync, i1.vblnk, ls1, fs1};
      default:
         return {i2.hcount, i2.vcount, i2.hsync, i2.hblnk,
                 i2.vsync, i2.vblnk, ls2, fs2};
    endcase
  endfunction

  task automatic step(input bit e);
    en = e;
    @(posedge clk);
    if (rst) begin
      adv = e;
      if (e) t++;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk($sformatf("model%0d", k), 28'(obs(k)), expv(k));
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s%0d", tag, k), 28'(obs(k)), 0);
  endtask

  // Line-level observations for d0 and d1.
  int fs0_seen = 0;
  int hb_first = -1;
  int hs_cnt = 0, hs_lo = 9999, hs_hi = -1;
  int hs1_lo = 9999, hs1_hi = -1;
  int ls1_at = -1;
  int nstep = 0;

  task automatic obs_line();
    nstep++;
    if (fs0) fs0_seen++;
    if (i0.hblnk && hb_first < 0) hb_first = int'(i0.hcount);
    if (i0.hsync) begin
      hs_cnt++;
      if (int'(i0.hcount) < hs_lo) hs_lo = int'(i0.hcount);
      if (int'(i0.hcount) > hs_hi) hs_hi = int'(i0.hcount);
    end
    if (i1.hsync) begin
      if (int'(i1.hcount) < hs1_lo) hs1_lo = int'(i1.hcount);
      if (int'(i1.hcount) > hs1_hi) hs1_hi = int'(i1.hcount);
    end
    if (ls1 && ls1_at < 0) ls1_at = nstep;
  endtask

  initial begin
    int nfs, fs_a, vs_cnt, vmax;
    int vs_lo, vs_hi, vb_lo, vb_hi;
    int dbl, found, seen;
    logic [27:0] prev;
    logic pfs, pls;

    #2 rst = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b1;

    // First line at default timing.
    step(1);
    obs_line();
    chk("h_after1", i0.hcount, 1);
    for (int i = 0; i < 1342; i++) begin
      step(1);
      obs_line();
    end
    chk("h_last", i0.hcount, 1343);
    step(1);
    obs_line();
    chk("h_wrap", i0.hcount, 0);
    chk("ls_wrap", ls0, 1);
    chk("v_after_line", i0.vcount, 1);
    chk("hb_fall", i0.hblnk, 0);
    chk("hs_fall", i0.hsync, 0);
    chk("fs_none_line", fs0_seen, 0);
    chk("hb_rise", hb_first, 1024);
    chk("hs_len", hs_cnt, 136);
    chk("hs_lo", hs_lo, 1048);
    chk("hs_hi", hs_hi, 1183);
    chk("d1_htotal", ls1_at, 800);
    chk("d1_hs_lo", hs1_lo, 656);
    chk("d1_hs_hi", hs1_hi, 751);

    // Full frame on d2 (12 x 525) with en held high.
    nfs = 0; fs_a = 0; vs_cnt = 0; vmax = 0;
    vs_lo = 9999; vs_hi = -1; vb_lo = 9999; vb_hi = -1;
    for (int i = 1; i <= 20000 && nfs < 2; i++) begin
      step(1);
      if (fs2) begin
        nfs++;
        if (nfs == 1) fs_a = i;
        else chk("d2_period", i - fs_a, 6300);
      end
      if (nfs == 1) begin
        if (int'(i2.vcount) > vmax) vmax = int'(i2.vcount);
        if (i2.vsync) begin
          vs_cnt++;
          if (int'(i2.vcount) < vs_lo) vs_lo = int'(i2.vcount);
          if (int'(i2.vcount) > vs_hi) vs_hi = int'(i2.vcount);
        end
        if (i2.vblnk) begin
          if (int'(i2.vcount) < vb_lo) vb_lo = int'(i2.vcount);
          if (int'(i2.vcount) > vb_hi) vb_hi = int'(i2.vcount);
        end
      end
    end
    chk("d2_frames", nfs, 2);
    chk("d2_vtotal", vmax + 1, 525);
    chk("d2_vs_len", vs_cnt, 2 * 12);
    chk("d2_vs_lo", vs_lo, 490);
    chk("d2_vs_hi", vs_hi, 491);
    chk("d2_vb_lo", vb_lo, 480);
    chk("d2_vb_hi", vb_hi, 524);

    // 50% enable: period doubles, outputs hold while idle.
    nfs = 0; fs_a = 0; dbl = 0;
    prev = obs(2);
    pfs = fs2; pls = ls2;
    for (int i = 1; i <= 40000 && nfs < 2; i++) begin
      step(i[0]);
      if (!i[0]) begin
        chk("hold", 28'(obs(2) >> 2), 28'(prev >> 2));
        chk("pulse_off", {ls2, fs2}, 0);
      end
      if ((fs2 && pfs) || (ls2 && pls)) dbl++;
      if (fs2) begin
        nfs++;
        if (nfs == 1) fs_a = i;
        else chk("d2_period_half", i - fs_a, 12600);
      end
      prev = obs(2);
      pfs = fs2; pls = ls2;
    end
    chk("d2_frames_half", nfs, 2);
    chk("pulse_width", dbl, 0);

    // Random enable against the model.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)));

    // Mid-frame reset once d2 reaches line 400.
    found = 0;
    for (int i = 0; i < 10000 && !found; i++) begin
      step(1);
      if (i2.vcount == 11'd400) found = 1;
    end
    chk("mid_frame_found", found, 1);
    rst = 1'b0;
    #1 chk_zero("rst_mid");
    t = 0;
    adv = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid_hold");
    rst = 1'b1;
    step(1);
    chk("resume_h", i0.hcount, 1);
    chk("resume_v", i0.vcount, 0);
    chk("resume_h2", i2.hcount, 1);
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (fs0 || fs1 || fs2) seen++;
    end
    chk("no_fs_after_rst", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
